// File: rtl/game_state_ctrl_pkg.sv
// game_state_ctrl_pkg: shared state encoding, frog spawn point and BCD width for the frog game
package game_state_ctrl_pkg;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PLAY = 3'd1,
        ST_HIT  = 3'd2,
        ST_GOAL = 3'd3,
        ST_OVER = 3'd4
    } state_t;
    localparam int SPAWN_X = 10;
    localparam int SPAWN_Y = 14;
    localparam int BCD_W   = 4;
    function automatic logic [3:0] lives_led(input logic [2:0] lives);
        for (int i = 0; i < 4; i++) lives_led[i] = lives > 3'(i);
    endfunction
endpackage

// File: rtl/game_state_ctrl_bcd_counter_2d.sv
// bcd_counter_2d: two-digit BCD incrementer that saturates at 99
module bcd_counter_2d
    import game_state_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             at_max
);
    assign at_max = tens == BCD_W'(9) && ones == BCD_W'(9);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc && !at_max) begin
            ones <= ones == BCD_W'(9) ? '0 : ones + BCD_W'(1);
            tens <= ones == BCD_W'(9) ? tens + BCD_W'(1) : tens;
        end
    end
endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: frog game sequencer owning lives, score and the play/hit/goal/over FSM.
// Define HISCORE_EN to add a high-score register latched on entry to game over.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int START_LIVES = 3,
    parameter int HIT_FRAMES  = 60,
    parameter int GOAL_FRAMES = 30
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_Start,
    input  logic       i_Frame_Tick,
    input  logic       i_Collision,
    input  logic       i_Goal,
    output logic       o_Move_En,
    output logic       o_Respawn,
    output logic [2:0] o_Lives,
    output logic [3:0] o_LED,
    output logic [3:0] o_Score_Tens,
    output logic [3:0] o_Score_Ones,
    output logic [2:0] o_State,
    output logic       o_Game_Over
`ifdef HISCORE_EN
    ,
    output logic [3:0] o_Hi_Tens,
    output logic [3:0] o_Hi_Ones
`endif
);
    state_t     r_state, w_nxt;
    logic [7:0] r_cnt;
    logic [2:0] r_lives, w_lives_nxt;
    logic [3:0] r_led;
    logic       r_move_en, r_respawn, r_game_over;
    logic       w_respawn, w_start, w_inc, w_clr, w_at_max;
    logic [BCD_W-1:0] w_tens, w_ones;

    always_comb begin
        w_nxt     = r_state;
        w_respawn = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: if (i_Start) begin
                w_nxt     = ST_PLAY;
                w_respawn = 1'b1;
            end
            ST_PLAY: if (i_Collision) w_nxt = r_lives <= 3'd1 ? ST_OVER : ST_HIT;
                     else if (i_Goal) w_nxt = ST_GOAL;
            ST_HIT, ST_GOAL: if (i_Frame_Tick && r_cnt == 8'd1) begin
                w_nxt     = ST_PLAY;
                w_respawn = 1'b1;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    assign w_start     = i_Start && (r_state == ST_IDLE || r_state == ST_OVER);
    assign w_lives_nxt = w_start ? 3'(START_LIVES)
                       : (r_state == ST_PLAY && i_Collision && r_lives != 3'd0) ? r_lives - 3'd1
                       : r_lives;
    // collision wins over a simultaneous goal, so the goal never scores
    assign w_inc = r_state == ST_PLAY && i_Goal && !i_Collision && !w_at_max;
    assign w_clr = r_state == ST_OVER && i_Start;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_lives     <= 3'(START_LIVES);
            r_led       <= lives_led(3'(START_LIVES));
            r_move_en   <= 1'b0;
            r_respawn   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_lives     <= w_lives_nxt;
            r_led       <= lives_led(w_lives_nxt);
            r_move_en   <= w_nxt == ST_PLAY;
            r_respawn   <= w_respawn;
            r_game_over <= w_nxt == ST_OVER;
            if (r_state == ST_PLAY && w_nxt == ST_HIT) r_cnt <= 8'(HIT_FRAMES);
            else if (r_state == ST_PLAY && w_nxt == ST_GOAL) r_cnt <= 8'(GOAL_FRAMES);
            else if ((r_state == ST_HIT || r_state == ST_GOAL) && i_Frame_Tick && r_cnt != 8'd0)
                r_cnt <= r_cnt - 8'd1;
        end
    end

    bcd_counter_2d u_score (
        .clk    (i_CLK),
        .rst    (i_RST),
        .clr    (w_clr),
        .inc    (w_inc),
        .tens   (w_tens),
        .ones   (w_ones),
        .at_max (w_at_max)
    );

`ifdef HISCORE_EN
    logic [7:0] r_hi;
    // packed BCD digits compare correctly as plain binary
    always_ff @(posedge i_CLK) begin
        if (i_RST) r_hi <= 8'd0;
        else if (r_state == ST_PLAY && w_nxt == ST_OVER && {w_tens, w_ones} > r_hi) r_hi <= {w_tens, w_ones};
    end
    assign o_Hi_Tens = r_hi[7:4];
    assign o_Hi_Ones = r_hi[3:0];
`endif

    assign o_Move_En    = r_move_en;
    assign o_Respawn    = r_respawn;
    assign o_Lives      = r_lives;
    assign o_LED        = r_led;
    assign o_Score_Tens = w_tens;
    assign o_Score_Ones = w_ones;
    assign o_State      = r_state;
    assign o_Game_Over  = r_game_over;
endmodule
